// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU function codes, slot state encoding and fn decode helpers
// for the two-requester ALU arbiter.
package alu_share_arbiter_pkg;

  localparam int ALU_FN_W = 5;

  localparam logic [ALU_FN_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALU_FN_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALU_FN_W-1:0] ALU_AND  = 5'd2;
  localparam logic [ALU_FN_W-1:0] ALU_OR   = 5'd3;
  localparam logic [ALU_FN_W-1:0] ALU_XOR  = 5'd4;
  localparam logic [ALU_FN_W-1:0] ALU_SLL  = 5'd5;
  localparam logic [ALU_FN_W-1:0] ALU_SRL  = 5'd6;
  localparam logic [ALU_FN_W-1:0] ALU_SRA  = 5'd7;
  localparam logic [ALU_FN_W-1:0] ALU_SLT  = 5'd8;
  localparam logic [ALU_FN_W-1:0] ALU_SLTU = 5'd9;
  localparam logic [ALU_FN_W-1:0] ALU_X    = 5'h10;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_FULL0 = 2'd1,
    SLOT_FULL1 = 2'd2
  } slot_state_e;

  // The ten defined ops occupy a contiguous code range starting at zero.
  function automatic logic alu_fn_legal(input logic [ALU_FN_W-1:0] fn);
    return (fn <= ALU_SLTU);
  endfunction

  function automatic logic alu_fn_is_shift(input logic [ALU_FN_W-1:0] fn);
    return (fn == ALU_SLL) || (fn == ALU_SRL) || (fn == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Plain combinational integer ALU; SRA and illegal codes are handled by the
// enclosing arbiter, so those codes simply return zero here.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int FN_W = ALU_FN_W
) (
  input  logic [FN_W-1:0] i_fn,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_fn)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_OR:   o_y = i_a | i_b;
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SLL:  o_y = i_a << i_b[4:0];
      ALU_SRL:  o_y = i_a >> i_b[4:0];
      ALU_SLT:  o_y = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_y = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters with a
// single registered result slot (1-cycle latency, drain+refill same cycle).
//
// state      | meaning
// SLOT_EMPTY | no result pending, any requester may be granted
// SLOT_FULL0 | result held for requester 0 (rsp0_valid high)
// SLOT_FULL1 | result held for requester 1 (rsp1_valid high)
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int FN_W = ALU_FN_W
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [FN_W-1:0] i_req0_fn,
  input  logic [XLEN-1:0] i_req0_a,
  input  logic [XLEN-1:0] i_req0_b,
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [FN_W-1:0] i_req1_fn,
  input  logic [XLEN-1:0] i_req1_a,
  input  logic [XLEN-1:0] i_req1_b,
  output logic            o_rsp0_valid,
  input  logic            i_rsp0_ready,
  output logic [XLEN-1:0] o_rsp0_data,
  output logic            o_rsp0_illegal,
  output logic            o_rsp1_valid,
  input  logic            i_rsp1_ready,
  output logic [XLEN-1:0] o_rsp1_data,
  output logic            o_rsp1_illegal
);

  slot_state_e     r_state;
  logic            r_last_grant;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_rsp_illegal;

  logic            w_slot_free;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_accept;
  logic [FN_W-1:0] w_fn;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_b_cond;
  logic [XLEN-1:0] w_alu_y;
  logic [XLEN-1:0] w_sra;
  logic            w_legal;
  logic [XLEN-1:0] w_result;

  assign w_slot_free = (r_state == SLOT_EMPTY) ||
                       ((r_state == SLOT_FULL0) && i_rsp0_ready) ||
                       ((r_state == SLOT_FULL1) && i_rsp1_ready);

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!i_rst && w_slot_free) begin
      if (i_req0_valid && i_req1_valid) begin
        w_grant0 = r_last_grant;
        w_grant1 = !r_last_grant;
      end else begin
        w_grant0 = i_req0_valid;
        w_grant1 = i_req1_valid;
      end
    end
  end

  assign w_accept     = w_grant0 || w_grant1;
  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;

  assign w_fn = w_grant1 ? i_req1_fn : i_req0_fn;
  assign w_a  = w_grant1 ? i_req1_a  : i_req0_a;
  assign w_b  = w_grant1 ? i_req1_b  : i_req0_b;

  assign w_legal  = alu_fn_legal(w_fn);
  assign w_b_cond = alu_fn_is_shift(w_fn) ? {{(XLEN-5){1'b0}}, w_b[4:0]} : w_b;

  alu_share_arbiter_alu #(
    .XLEN (XLEN),
    .FN_W (FN_W)
  ) u_alu (
    .i_fn (w_fn),
    .i_a  (w_a),
    .i_b  (w_b_cond),
    .o_y  (w_alu_y)
  );

  // Sign fill is done here so it never depends on the shared ALU's SRA.
  assign w_sra    = $signed(w_a) >>> w_b_cond[4:0];
  assign w_result = !w_legal          ? '0    :
                    (w_fn == ALU_SRA) ? w_sra : w_alu_y;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= SLOT_EMPTY;
      r_last_grant  <= 1'b1;
      r_rsp_data    <= '0;
      r_rsp_illegal <= 1'b0;
    end else if (w_accept) begin
      r_state       <= w_grant1 ? SLOT_FULL1 : SLOT_FULL0;
      r_last_grant  <= w_grant1;
      r_rsp_data    <= w_result;
      r_rsp_illegal <= !w_legal;
    end else if (w_slot_free) begin
      r_state <= SLOT_EMPTY;
    end
  end

  assign o_rsp0_valid   = (r_state == SLOT_FULL0);
  assign o_rsp1_valid   = (r_state == SLOT_FULL1);
  assign o_rsp0_data    = r_rsp_data;
  assign o_rsp1_data    = r_rsp_data;
  assign o_rsp0_illegal = r_rsp_illegal;
  assign o_rsp1_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural slot model.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int XLEN = 32;
  localparam int FN_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [FN_W-1:0] req0_fn, req1_fn;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic            rsp0_valid, rsp0_ready, rsp0_illegal;
  logic            rsp1_valid, rsp1_ready, rsp1_illegal;
  logic [XLEN-1:0] rsp0_data, rsp1_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(XLEN), .FN_W(FN_W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req0_valid   (req0_valid),
    .o_req0_ready   (req0_ready),
    .i_req0_fn      (req0_fn),
    .i_req0_a       (req0_a),
    .i_req0_b       (req0_b),
    .i_req1_valid   (req1_valid),
    .o_req1_ready   (req1_ready),
    .i_req1_fn      (req1_fn),
    .i_req1_a       (req1_a),
    .i_req1_b       (req1_b),
    .o_rsp0_valid   (rsp0_valid),
    .i_rsp0_ready   (rsp0_ready),
    .o_rsp0_data    (rsp0_data),
    .o_rsp0_illegal (rsp0_illegal),
    .o_rsp1_valid   (rsp1_valid),
    .i_rsp1_ready   (rsp1_ready),
    .o_rsp1_data    (rsp1_data),
    .o_rsp1_illegal (rsp1_illegal)
  );

  typedef struct {
    logic            req;
    logic [FN_W-1:0] fn;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    logic            ill;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_fn = ALU_ADD; req1_fn = ALU_ADD;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Reference ALU from plain arithmetic; bit 32 flags an illegal code.
  function automatic logic [32:0] alu_ref(input logic [FN_W-1:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] ones;
    sh   = b % 32;
    ones = 32'hFFFF_FFFF;
    case (fn)
      ALU_ADD:  return {1'b0, a + b};
      ALU_SUB:  return {1'b0, a - b};
      ALU_AND:  return {1'b0, a & b};
      ALU_OR:   return {1'b0, a | b};
      ALU_XOR:  return {1'b0, a ^ b};
      ALU_SLL:  return {1'b0, a << sh};
      ALU_SRL:  return {1'b0, a >> sh};
      ALU_SRA:  return {1'b0, (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0)};
      ALU_SLT:  return {1'b0, 31'h0, ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000))};
      ALU_SLTU: return {1'b0, 31'h0, (a < b)};
      default:  return {1'b1, 32'h0};
    endcase
  endfunction

  initial begin
    vecs[0]  = '{1'b0, ALU_ADD,  32'd5,         32'd7,         32'd12,        1'b0};
    vecs[1]  = '{1'b1, ALU_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0};
    vecs[2]  = '{1'b1, ALU_SRL,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0};
    vecs[3]  = '{1'b0, ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
    vecs[4]  = '{1'b0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
    vecs[5]  = '{1'b1, ALU_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
    vecs[6]  = '{1'b0, ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0};
    vecs[7]  = '{1'b1, ALU_OR,   32'h0000_1200, 32'h0000_0034, 32'h0000_1234, 1'b0};
    vecs[8]  = '{1'b0, ALU_XOR,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0};
    vecs[9]  = '{1'b1, ALU_SLL,  32'd1,         32'h0000_0021, 32'd2,         1'b0};
    vecs[10] = '{1'b0, ALU_SRA,  32'h7FFF_FFF0, 32'd4,         32'h07FF_FFFF, 1'b0};
    vecs[11] = '{1'b1, ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
    vecs[12] = '{1'b1, 5'h0B,    32'd1,         32'd1,         32'd0,         1'b1};
    vecs[13] = '{1'b0, ALU_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};

    idle;
    do_reset;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst req0_ready", req0_ready, 0);
    chk("rst req1_ready", req1_ready, 0);
    chk("rst rsp0_valid", rsp0_valid, 0);
    chk("rst rsp1_valid", rsp1_valid, 0);
    chk("rst rsp0_data", rsp0_data, 0);
    chk("rst rsp1_data", rsp1_data, 0);
    chk("rst rsp0_illegal", rsp0_illegal, 0);
    chk("rst rsp1_illegal", rsp1_illegal, 0);
    tick;
    idle;
    rst = 1'b0;

    // Directed vector table, one requester at a time.
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].req) begin
        req1_valid = 1'b1; req1_fn = vecs[i].fn; req1_a = vecs[i].a; req1_b = vecs[i].b;
      end else begin
        req0_valid = 1'b1; req0_fn = vecs[i].fn; req0_a = vecs[i].a; req0_b = vecs[i].b;
      end
      #1;
      chk($sformatf("vec%0d ready", i), vecs[i].req ? req1_ready : req0_ready, 1);
      tick;
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk($sformatf("vec%0d rsp0_valid", i), rsp0_valid, !vecs[i].req);
      chk($sformatf("vec%0d rsp1_valid", i), rsp1_valid, vecs[i].req);
      chk($sformatf("vec%0d data", i), vecs[i].req ? rsp1_data : rsp0_data, vecs[i].exp);
      chk($sformatf("vec%0d illegal", i), vecs[i].req ? rsp1_illegal : rsp0_illegal,
          vecs[i].ill);
      tick;
      chk($sformatf("vec%0d drain", i), vecs[i].req ? rsp1_valid : rsp0_valid, 0);
    end

    // Contention: grants alternate starting with requester 0, one result per cycle.
    do_reset;
    req0_valid = 1'b1; req0_fn = ALU_SUB; req0_a = 32'd10;        req0_b = 32'd3;
    req1_valid = 1'b1; req1_fn = ALU_XOR; req1_a = 32'h0000_F0F0; req1_b = 32'h0000_0FF0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("alt%0d req0_ready", k), req0_ready, (k % 2) == 0);
      chk($sformatf("alt%0d req1_ready", k), req1_ready, (k % 2) == 1);
      tick;
      chk($sformatf("alt%0d rsp0_valid", k), rsp0_valid, (k % 2) == 0);
      chk($sformatf("alt%0d rsp1_valid", k), rsp1_valid, (k % 2) == 1);
      chk($sformatf("alt%0d data", k), (k % 2) ? rsp1_data : rsp0_data,
          (k % 2) ? 32'h0000_FF00 : 32'd7);
    end
    idle;
    tick;

    // Backpressure: requester 1 blocked behind an unclaimed requester-0 result.
    req0_valid = 1'b1; req0_fn = ALU_ADD; req0_a = 32'd100; req0_b = 32'd23;
    #1;
    chk("bp req0_ready", req0_ready, 1);
    tick;
    req0_valid = 1'b0; rsp0_ready = 1'b0;
    req0_a = 32'hDEAD_BEEF;
    req1_valid = 1'b1; req1_fn = ALU_OR; req1_a = 32'h0000_00A0; req1_b = 32'h0000_000B;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d req1_ready", k), req1_ready, 0);
      chk($sformatf("bp%0d rsp0_valid", k), rsp0_valid, 1);
      chk($sformatf("bp%0d rsp0_data", k), rsp0_data, 32'd123);
      tick;
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp release req1_ready", req1_ready, 1);
    tick;
    req1_valid = 1'b0;
    chk("bp rsp1_valid", rsp1_valid, 1);
    chk("bp rsp0_valid", rsp0_valid, 0);
    chk("bp rsp1_data", rsp1_data, 32'h0000_00AB);
    tick;

    // Illegal codes, then reset while the slot holds a result.
    req0_valid = 1'b1; req0_fn = ALU_X; req0_a = 32'h1234_5678; req0_b = 32'h9;
    tick;
    chk("ill X valid", rsp0_valid, 1);
    chk("ill X data", rsp0_data, 0);
    chk("ill X illegal", rsp0_illegal, 1);
    req0_fn = 5'h1F;
    #1;
    chk("ill 1F ready", req0_ready, 1);
    tick;
    req0_valid = 1'b0; rsp0_ready = 1'b0;
    chk("ill 1F data", rsp0_data, 0);
    chk("ill 1F illegal", rsp0_illegal, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    rsp0_ready = 1'b1;
    chk("midrst rsp0_valid", rsp0_valid, 0);
    req0_valid = 1'b1; req0_fn = ALU_ADD;
    req1_valid = 1'b1; req1_fn = ALU_ADD;
    #1;
    chk("midrst req0_ready", req0_ready, 1);
    chk("midrst req1_ready", req1_ready, 0);
    tick;
    idle;
    tick;

    // Randomized traffic against the behavioural slot model.
    begin
      int          m_owner;
      int          m_last;
      logic [31:0] m_data;
      logic        m_ill;
      logic [32:0] r;
      int          g;
      logic        free;
      do_reset;
      m_owner = -1; m_last = 1; m_data = '0; m_ill = 1'b0;
      for (int c = 0; c < 400; c++) begin
        rst        = ($urandom_range(0, 39) == 0);
        req0_valid = $urandom_range(0, 1) != 0;
        req1_valid = $urandom_range(0, 2) != 0;
        req0_fn    = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
        req1_fn    = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
        req0_a     = $urandom;
        req1_a     = $urandom;
        req0_b     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
        req1_b     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
        rsp0_ready = $urandom_range(0, 3) != 0;
        rsp1_ready = $urandom_range(0, 3) != 0;
        #1;
        free = (m_owner < 0) || (m_owner == 0 && rsp0_ready) || (m_owner == 1 && rsp1_ready);
        g = -1;
        if (!rst && free) begin
          if (req0_valid && req1_valid) g = (m_last == 1) ? 0 : 1;
          else if (req0_valid)          g = 0;
          else if (req1_valid)          g = 1;
        end
        chk($sformatf("rnd%0d req0_ready", c), req0_ready, g == 0);
        chk($sformatf("rnd%0d req1_ready", c), req1_ready, g == 1);
        if (rst) begin
          m_owner = -1; m_last = 1;
        end else if (g >= 0) begin
          r = (g == 1) ? alu_ref(req1_fn, req1_a, req1_b) : alu_ref(req0_fn, req0_a, req0_b);
          m_owner = g; m_last = g; m_data = r[31:0]; m_ill = r[32];
        end else if (free) begin
          m_owner = -1;
        end
        tick;
        chk($sformatf("rnd%0d rsp0_valid", c), rsp0_valid, m_owner == 0);
        chk($sformatf("rnd%0d rsp1_valid", c), rsp1_valid, m_owner == 1);
        if (m_owner == 0) begin
          chk($sformatf("rnd%0d rsp0_data", c), rsp0_data, m_data);
          chk($sformatf("rnd%0d rsp0_illegal", c), rsp0_illegal, m_ill);
        end else if (m_owner == 1) begin
          chk($sformatf("rnd%0d rsp1_data", c), rsp1_data, m_data);
          chk($sformatf("rnd%0d rsp1_illegal", c), rsp1_illegal, m_ill);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU instance between two requesters using valid/ready handshakes.
  - Requester 0 is the EX-stage integer path.
  - Requester 1 is the branch/address-calc or multi-cycle sequencer path.
- Arbitration is round-robin. There is one registered result slot, so results return one cycle after acceptance.
- The block conditions operands before they reach the ALU: shift-amount masking and illegal-fn detection.

Parameters:
- XLEN, 32, operand/result width
- FN_W, 5, ALU function-code width (matches the `ALU_*` codes)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_fn  in  FN_W  ALU function code
- req0_a  in  XLEN  operand A (rs1)
- req0_b  in  XLEN  operand B (rs2/imm)
- req1_valid, req1_ready, req1_fn, req1_a, req1_b  same as requester 0, for requester 1
- rsp0_valid  out  1  result for requester 0 pending
- rsp0_ready  in  1  requester 0 takes result
- rsp0_data  out  XLEN  result
- rsp0_illegal  out  1  fn was `ALU_X` or an undefined code
- rsp1_valid, rsp1_ready, rsp1_data, rsp1_illegal  same as requester 0, for requester 1

Behaviour:
- Reset (rst=1 at posedge):
  - rsp*_valid=0, rsp*_data=0, rsp*_illegal=0.
  - Slot empty; last_grant=1, so requester 0 wins first.
  - req*_ready=0 while rst is high.
- Slot state: EMPTY, or FULL(owner). Only the owner's rsp_valid is high; the other requester's is 0.
- slot_free = EMPTY, or (FULL and rsp_owner_ready), i.e. drain and refill in the same cycle.
- Grant is combinational, when slot_free:
  - Only one requester valid → grant it.
  - Both valid → grant the one not equal to last_grant.
- reqN_ready = grant_N. Ready may depend on valid; valid must never depend on ready.
- Accept = reqN_valid & reqN_ready. At that posedge:
  - slot loads the result and owner=N; last_grant=N.
  - rspN_valid=1 in the next cycle. Latency is exactly 1 cycle.
- Throughput: 1 op/cycle while the owner holds rsp_ready=1, including alternating owners.
- Backpressure: while FULL and the owner's rsp_ready=0:
  - No grants.
  - rsp data/illegal held stable.
  - The other requester stalls (head-of-line blocking is intended).
- Drain without a new accept: slot→EMPTY, rsp_valid drops next cycle.
- Operand conditioning before the ALU:
  - `ALU_SLL`/`ALU_SRL`/`ALU_SRA`: B masked to B[4:0], zero-extended.
  - `ALU_SRA` must sign-fill from A[31]; the block guarantees this regardless of ALU internals (computes via $signed).
- Illegal fn (`ALU_X` or any code outside the ten defined ops):
  - Still accepted with normal handshake.
  - Result = 0, illegal=1. X never propagates to rsp_data.
- SLT is signed, SLTU unsigned; result is 0 or 1 zero-extended. ADD/SUB wrap modulo 2^XLEN.
- Request inputs are sampled only on the accept cycle. Changes while not ready are legal and ignored.
- rst mid-operation: a pending result is discarded, no rsp is produced, and last_grant returns to 1.

Decomposition:
- `ALU_*` function codes stay in the shared define.vh include.
- Add to define.vh: ALU_FN_W=5, and a `ALU_FN_LEGAL` check macro (or a function in the same include).
- One sub-module: instantiate the existing ALU unchanged for ADD/SUB/AND/OR/XOR/SLL/SRL/SLT/SLTU.
- SRA override and illegal masking live in this block.

Test Plan:
- Reset release, req0 ADD a=5 b=7 → req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp0_data=12, rsp1_valid=0.
- Both valid every cycle, rsp ready=1, req0 SUB 10-3, req1 XOR 0xF0F0^0x0FF0:
  - Grants alternate 0,1,0,1 (0 first).
  - rsp0_data=7, rsp1_data=0x0000FF00.
  - One result per cycle.
- req1 SRA a=0x80000000 b=0x00000024 → B masked to 4; rsp1_data=0xF8000000. SRL same operands → 0x08000000.
- req0 SLT a=0xFFFFFFFF b=1 → 1; SLTU same operands → 0.
- Backpressure: rsp0_ready=0 for 3 cycles with req1 valid:
  - req1_ready=0 throughout; rsp0_data stable.
  - rsp0_ready=1 → same-cycle grant to req1; rsp1_valid the following cycle.
- req0 fn=`ALU_X`, then fn=5'h1F → rsp0_data=0, rsp0_illegal=1 both times, no X. Then assert rst while the slot is FULL → rsp0_valid=0 the cycle after, and the next contended grant goes to req0.
